// File: rtl/uart_pkg.sv
// Frame-format definitions shared by the UART transmitter and receiver.
// Both ends import this package so they agree on states, parity sense and word width.
package uart_pkg;

    localparam int   DEFAULT_DATA_WIDTH = 8;
    localparam logic PAR_EVEN           = 1'b0;
    localparam logic PAR_ODD            = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // data_xor is the XOR reduction of the word; the result makes the total count of ones even or odd.
    function automatic logic parity_bit(input logic data_xor, input logic par_typ);
        return (par_typ == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Holds the accepted word as a right-shifting register and counts data bits on the line.
// cur_bit/next_bit let the core pre-compute its registered TX_OUT one cycle ahead.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  cur_bit,
    output logic                  next_bit,
    output logic                  done
);

    localparam int             CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      cnt_reg;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else if (load) begin
            shift_reg <= data_in;
            cnt_reg   <= '0;
        end else if (shift_en) begin
            shift_reg <= shift_reg >> 1;
            // Saturate at the last index; the FSM leaves DATA on done before any wrap.
            if (cnt_reg != LAST_IDX) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign cur_bit  = shift_reg[0];
    assign next_bit = shift_reg[1];
    assign done     = (cnt_reg == LAST_IDX);

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start, DATA_WIDTH data bits LSB-first, optional parity, stop; one bit per CLK.
// TX_OUT and BUSY are flops loaded from the next-state decode so they line up with the FSM state.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    uart_state_t state_reg, state_next;
    logic        tx_reg, tx_next;
    logic        busy_reg, busy_next;
    logic        par_en_reg, parity_reg;
    logic        load, shift_en;
    logic        ser_cur_bit, ser_next_bit, ser_done;

    uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_serializer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (load),
        .shift_en (shift_en),
        .data_in  (P_DATA),
        .cur_bit  (ser_cur_bit),
        .next_bit (ser_next_bit),
        .done     (ser_done)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg  <= ST_IDLE;
            tx_reg     <= 1'b1;
            busy_reg   <= 1'b0;
            par_en_reg <= 1'b0;
            parity_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            tx_reg    <= tx_next;
            busy_reg  <= busy_next;
            if (load) begin
                par_en_reg <= PAR_EN;
                parity_reg <= parity_bit(^P_DATA, PAR_TYP);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
        load       = 1'b0;
        shift_en   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (DATA_VALID) begin
                    load       = 1'b1;
                    state_next = ST_START;
                    tx_next    = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            ST_START: begin
                state_next = ST_DATA;
                tx_next    = ser_cur_bit;
                busy_next  = 1'b1;
            end
            ST_DATA: begin
                busy_next = 1'b1;
                if (ser_done) begin
                    if (par_en_reg) begin
                        state_next = ST_PARITY;
                        tx_next    = parity_reg;
                    end else begin
                        state_next = ST_STOP;
                    end
                end else begin
                    shift_en = 1'b1;
                    tx_next  = ser_next_bit;
                end
            end
            ST_PARITY: begin
                state_next = ST_STOP;
                busy_next  = 1'b1;
            end
            ST_STOP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign TX_OUT = tx_reg;
    assign BUSY   = busy_reg;

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: a frame-queue line model checked every cycle, plus literal frame captures.
module tb_uart_tx_core;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       BUSY;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 CLK = ~CLK;

    uart_tx_core #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .BUSY       (BUSY)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Line model: queue of bits still to appear on the line; front is the bit currently shown.
    bit exp_q[$];
    bit was_busy;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            exp_q.delete();
        end else begin
            was_busy = (exp_q.size() != 0);
            if (was_busy) void'(exp_q.pop_front());
            if (!was_busy && DATA_VALID === 1'b1) begin
                exp_q.push_back(1'b0);
                for (int b = 0; b < 8; b++) exp_q.push_back(P_DATA[b]);
                if (PAR_EN) exp_q.push_back((($countones(P_DATA) % 2) == 1) ^ PAR_TYP);
                exp_q.push_back(1'b1);
            end
        end
    end

    always @(negedge CLK) begin
        if (RST && chk_en) begin
            check("model_tx", {31'd0, TX_OUT}, (exp_q.size() != 0) ? {31'd0, exp_q[0]} : 32'd1);
            check("model_busy", {31'd0, BUSY}, {31'd0, exp_q.size() != 0});
        end
    end

    // Caller raises DATA_VALID just after a falling edge; log bit i is the line in frame cycle i.
    task automatic capture(input int n, input int drop_at, input int pulse_at,
                           input int change_at, input logic [7:0] change_val, input bit flip_par,
                           output logic [31:0] txlog, output int busy_cnt);
        logic [7:0] d0;
        logic       pe0, pt0;
        d0 = P_DATA; pe0 = PAR_EN; pt0 = PAR_TYP;
        txlog = '1;
        busy_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (i == drop_at || i == pulse_at + 1) DATA_VALID = 1'b0;
            if (i == pulse_at) DATA_VALID = 1'b1;
            if (i == change_at) begin
                P_DATA = change_val;
                if (flip_par) begin
                    PAR_EN  = ~PAR_EN;
                    PAR_TYP = ~PAR_TYP;
                end
            end
            txlog[i] = TX_OUT;
            if (BUSY) busy_cnt++;
        end
        $display("frame p_data=%h par_en=%b par_typ=%b line=%h busy_cycles=%0d",
                 d0, pe0, pt0, txlog, busy_cnt);
    endtask

    logic [31:0] log_v;
    int          bc;

    initial begin
        P_DATA = 8'h00; DATA_VALID = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_tx", {31'd0, TX_OUT}, 32'd1);
        check("reset_busy", {31'd0, BUSY}, 32'd0);
        @(negedge CLK);
        #2 RST = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge CLK);

        // 0xA5 without parity
        P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
        capture(14, 0, -10, -1, 8'h00, 1'b0, log_v, bc);
        check("t1_line", log_v & 32'h3FFF, 32'h3F4A);
        check("t1_busy", bc, 32'd10);

        // 0xA5 even then odd parity
        P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
        capture(14, 0, -10, -1, 8'h00, 1'b0, log_v, bc);
        check("t2_even_line", log_v & 32'h3FFF, 32'h3D4A);
        check("t2_even_busy", bc, 32'd11);
        P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b1; DATA_VALID = 1'b1;
        capture(14, 0, -10, -1, 8'h00, 1'b0, log_v, bc);
        check("t2_odd_line", log_v & 32'h3FFF, 32'h3F4A);
        check("t2_odd_busy", bc, 32'd11);

        // 0x07 even parity, inputs disturbed mid-frame
        P_DATA = 8'h07; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
        capture(14, 0, -10, 3, 8'hFF, 1'b1, log_v, bc);
        check("t3_line", log_v & 32'h3FFF, 32'h3E0E);
        check("t3_busy", bc, 32'd11);
        PAR_EN = 1'b0; PAR_TYP = 1'b0;

        // DATA_VALID held: 0x3C then 0xC3 back to back
        P_DATA = 8'h3C; DATA_VALID = 1'b1;
        capture(24, 12, -10, 2, 8'hC3, 1'b0, log_v, bc);
        check("t4_line", log_v & 32'hFF_FFFF, 32'hFC3678);
        check("t4_busy", bc, 32'd20);

        // request pulse during DATA is ignored
        P_DATA = 8'hA5; PAR_EN = 1'b0; DATA_VALID = 1'b1;
        capture(14, 0, 4, -1, 8'h00, 1'b0, log_v, bc);
        check("t5_line", log_v & 32'h3FFF, 32'h3F4A);
        check("t5_busy", bc, 32'd10);

        // reset during data bit 4
        P_DATA = 8'hA5; PAR_EN = 1'b0; DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        repeat (5) @(negedge CLK);
        check("t6_bit4", {31'd0, TX_OUT}, 32'd0);
        #2 RST = 1'b0;
        #1;
        check("t6_abort_tx", {31'd0, TX_OUT}, 32'd1);
        check("t6_abort_busy", {31'd0, BUSY}, 32'd0);
        $display("frame aborted by reset during data bit 4");
        @(negedge CLK);
        #2 RST = 1'b1;
        @(negedge CLK);
        P_DATA = 8'hA5; DATA_VALID = 1'b1;
        capture(14, 0, -10, -1, 8'h00, 1'b0, log_v, bc);
        check("t6_line", log_v & 32'h3FFF, 32'h3F4A);
        check("t6_busy", bc, 32'd10);

        repeat (2) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
